// File: rtl/slt_pkg.sv
// Shared constants for the sequential set-less-than block: default sizing and FSM state encoding.
package slt_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefChunk = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of a ripple subtractor: diff = a - b - borrow_in, plus slice equality.
module sub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] diff,
  output logic             borrow_out,
  output logic             slice_eq
);

  logic [CHUNK:0] wide;

  // Extra top bit of the widened subtraction is set exactly when the slice underflows.
  always_comb begin
    wide       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    diff       = wide[CHUNK-1:0];
    borrow_out = wide[CHUNK];
    slice_eq   = (a == b);
  end

endmodule

// File: rtl/slt_seq.sv
// Sequential a < b comparator: subtracts CHUNK bits per cycle, LSB slice first, and reports
// lt in res[0] plus a == b in eq. Define SLT_SEQ_SIGNED_EN to honour is_signed (two's
// complement compare); without it the compare is always unsigned.
module slt_seq
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             eq
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              eq_acc_q, eq_acc_d;
  logic              lt_q, lt_d;
  logic              eq_q, eq_d;

  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [CHUNK-1:0]  slice_diff_unused;
  logic              borrow_out;
  logic              slice_eq;
  logic              lt_final;

  // Current slice is selected by shifting the held operands down by the chunk index.
  assign a_sh = a_q >> (cnt_q * CHUNK);
  assign b_sh = b_q >> (cnt_q * CHUNK);

  sub_chunk #(
    .CHUNK(CHUNK)
  ) u_sub_chunk (
    .a         (a_sh[CHUNK-1:0]),
    .b         (b_sh[CHUNK-1:0]),
    .borrow_in (borrow_q),
    .diff      (slice_diff_unused),
    .borrow_out(borrow_out),
    .slice_eq  (slice_eq)
  );

`ifdef SLT_SEQ_SIGNED_EN
  logic sgn_q, sgn_d;
  // Differing sign bits decide a signed compare outright; otherwise the borrow does.
  assign lt_final = (sgn_q && (a_q[WIDTH-1] != b_q[WIDTH-1])) ? a_q[WIDTH-1] : borrow_out;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign lt_final         = borrow_out;
`endif

  // Next-state logic for the IDLE -> RUN -> DONE operation sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    eq_acc_d = eq_acc_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
`ifdef SLT_SEQ_SIGNED_EN
    sgn_d    = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          borrow_d = 1'b0;
          eq_acc_d = 1'b1;
`ifdef SLT_SEQ_SIGNED_EN
          sgn_d    = is_signed;
`endif
          state_d  = StRun;
        end
      end
      StRun: begin
        cnt_d    = cnt_q + 1'b1;
        borrow_d = borrow_out;
        eq_acc_d = eq_acc_q & slice_eq;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          lt_d    = lt_final;
          eq_d    = eq_acc_q & slice_eq;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      eq_acc_q <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      eq_acc_q <= eq_acc_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

`ifdef SLT_SEQ_SIGNED_EN
  // Signed-mode flag captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign res       = {{(WIDTH-1){1'b0}}, lt_q};
  assign eq        = eq_q;

endmodule

// File: tb/tb_slt_seq.sv
// Scoreboard bench for slt_seq: the driver queues expected results, a negedge monitor checks
// every cycle out_valid is high. A second WIDTH=CHUNK=8 instance covers the single-slice case.
module tb_slt_seq;

`ifdef SLT_SEQ_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif
  localparam int ExpLat = 5;  // accept edge counted as edge 1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        eq;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       is_signed8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] res8;
  logic       eq8;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int acc_edge = 0;

  typedef struct {
    logic lt;
    logic eq;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic ov_prev = 1'b0;

  slt_seq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .eq       (eq)
  );

  slt_seq #(
    .WIDTH(8),
    .CHUNK(8)
  ) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a        (a8),
    .b        (b8),
    .is_signed(is_signed8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .res      (res8),
    .eq       (eq8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation when out_valid rises, then checks it every held cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_edge = edge_cnt + 1;
      if (out_valid) begin
        if (!ov_prev) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
            cur.lt = 1'bx;
            cur.eq = 1'bx;
          end else begin
            cur = sb_q.pop_front();
            chk("latency", 32'(edge_cnt - acc_edge + 1), 32'(ExpLat));
          end
        end
        chk("res", res, {31'd0, cur.lt});
        chk("eq", {31'd0, eq}, {31'd0, cur.eq});
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      end
      ov_prev = out_valid;
    end
  end

  // One operation; hold > 0 keeps out_ready low that many cycles while offering a new op.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        input logic exp_lt, input logic exp_eq, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    a         = av;
    b         = bv;
    is_signed = sv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    e.lt      = exp_lt;
    e.eq      = exp_eq;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = ~av;
    b         = ~bv;
    is_signed = ~sv;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_reached", {31'd0, out_valid}, 32'd1);
    if (!out_valid) sb_q.delete();
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        a         = 32'd0;
        b         = 32'd1;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        chk("no_accept_from_done", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int n;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_eq", {31'd0, eq}, 32'd0);
    chk("rst8_in_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, SignedEn, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 1'b0, 0);
    run_op(32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, ~SignedEn, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 0);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
    // Result held in DONE for 3 cycles while a competing request is offered.
    run_op(32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 3);

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    a        = 32'd0;
    b        = 32'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
    run_op(32'd3, 32'd2, 1'b0, 1'b0, 1'b0, 0);

    // Single-slice instance: 0x80 vs 0x7F signed.
    @(negedge clk);
    a8         = 8'h80;
    b8         = 8'h7F;
    is_signed8 = 1'b1;
    in_valid8  = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    a8        = 8'h00;
    b8        = 8'hFF;
    n = 1;
    while (!out_valid8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("n1_out_valid", {31'd0, out_valid8}, 32'd1);
    chk("n1_latency", 32'(n), 32'd2);
    chk("n1_res", {24'd0, res8}, {31'd0, SignedEn});
    chk("n1_eq", {31'd0, eq8}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (checks %0d, failures %0d)",
             n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
